// File: rtl/ship_placement_ctrl_if.sv
// ----------------------------------------------------------------------------
// ship_placement_ctrl_if
// Bundles the player-facing inputs and the ship-register-facing outputs of
// the placement controller.
//   master : drives i_start / i_btn_* (button logic), observes o_* outputs
//   slave  : the placement controller itself
// Signals:
//   i_start        begin/restart placement
//   i_btn_up/down/left/right/confirm   single-cycle button pulses
//   o_cursor       current cursor cell index (row*COLS+col)
//   o_cell_out     cell index for the ship position registers
//   o_ship_we      one-hot write enable, one bit per ship register
//   o_ship_clr     one-cycle clear pulse for all ship registers
//   o_occupied     bit i set when cell i holds a placed ship
//   o_ships_placed number of ships written so far
//   o_reject       one-cycle pulse: confirm landed on an occupied cell
//   o_busy         placement in progress
//   o_done         all ships placed
// ----------------------------------------------------------------------------
interface ship_placement_ctrl_if #(
    parameter int NUM_SHIPS = 5,
    parameter int ROWS      = 5,
    parameter int COLS      = 5
);
    localparam int NCELLS = ROWS * COLS;
    localparam int PW     = $clog2(NUM_SHIPS + 1);

    logic                 i_start;
    logic                 i_btn_up;
    logic                 i_btn_down;
    logic                 i_btn_left;
    logic                 i_btn_right;
    logic                 i_btn_confirm;
    logic [4:0]           o_cursor;
    logic [4:0]           o_cell_out;
    logic [NUM_SHIPS-1:0] o_ship_we;
    logic                 o_ship_clr;
    logic [NCELLS-1:0]    o_occupied;
    logic [PW-1:0]        o_ships_placed;
    logic                 o_reject;
    logic                 o_busy;
    logic                 o_done;

    modport master (
        output i_start, i_btn_up, i_btn_down, i_btn_left, i_btn_right, i_btn_confirm,
        input  o_cursor, o_cell_out, o_ship_we, o_ship_clr, o_occupied,
               o_ships_placed, o_reject, o_busy, o_done
    );

    modport slave (
        input  i_start, i_btn_up, i_btn_down, i_btn_left, i_btn_right, i_btn_confirm,
        output o_cursor, o_cell_out, o_ship_we, o_ship_clr, o_occupied,
               o_ships_placed, o_reject, o_busy, o_done
    );
endinterface

// File: rtl/ship_placement_ctrl.sv
// ----------------------------------------------------------------------------
// ship_placement_ctrl
// Placement-phase sequencer for the battleship game. Moves a board cursor
// from button pulses, checks each confirmed cell against already placed
// ships, and write-enables the next ship position register with the cell.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   sp   ship_placement_ctrl_if.slave (buttons in, ship register controls out)
// ----------------------------------------------------------------------------
module ship_placement_ctrl #(
    parameter int NUM_SHIPS = 5,
    parameter int ROWS      = 5,
    parameter int COLS      = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    ship_placement_ctrl_if.slave  sp
);
    localparam int NCELLS = ROWS * COLS;
    localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CLW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int IW     = (NUM_SHIPS > 1) ? $clog2(NUM_SHIPS) : 1;
    localparam int PW     = $clog2(NUM_SHIPS + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_SELECT = 3'd2,
        S_CHECK  = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t               r_state;
    logic [RW-1:0]        r_row;
    logic [CLW-1:0]       r_col;
    logic [4:0]           r_cursor;
    logic [NUM_SHIPS-1:0] r_ship_we;
    logic                 r_ship_clr;
    logic [NCELLS-1:0]    r_occupied;
    logic [PW-1:0]        r_ships_placed;
    logic [IW-1:0]        r_ship_idx;
    logic                 r_reject;
    logic                 r_busy;
    logic                 r_done;

    logic [RW-1:0]        w_row_nxt;
    logic [CLW-1:0]       w_col_nxt;
    logic [4:0]           w_cursor_nxt;
    logic                 w_move;
    logic [NCELLS-1:0]    w_cell_mask;

    // Next cursor position for a move button; up > down > left > right, all wrapping.
    always_comb begin
        w_row_nxt = r_row;
        w_col_nxt = r_col;
        if (sp.i_btn_up) begin
            w_row_nxt = (r_row == RW'(0)) ? RW'(ROWS - 1) : r_row - RW'(1);
        end else if (sp.i_btn_down) begin
            w_row_nxt = (r_row == RW'(ROWS - 1)) ? RW'(0) : r_row + RW'(1);
        end else if (sp.i_btn_left) begin
            w_col_nxt = (r_col == CLW'(0)) ? CLW'(COLS - 1) : r_col - CLW'(1);
        end else if (sp.i_btn_right) begin
            w_col_nxt = (r_col == CLW'(COLS - 1)) ? CLW'(0) : r_col + CLW'(1);
        end else begin
            w_row_nxt = r_row;
            w_col_nxt = r_col;
        end
        w_cursor_nxt = 5'(32'(w_row_nxt) * 32'(COLS) + 32'(w_col_nxt));
    end

    assign w_move      = sp.i_btn_up | sp.i_btn_down | sp.i_btn_left | sp.i_btn_right;
    assign w_cell_mask = NCELLS'(1) << r_cursor;

    // Placement FSM; every output is registered alongside the state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_row          <= RW'(0);
            r_col          <= CLW'(0);
            r_cursor       <= 5'd0;
            r_ship_we      <= '0;
            r_ship_clr     <= 1'b0;
            r_occupied     <= '0;
            r_ships_placed <= PW'(0);
            r_ship_idx     <= IW'(0);
            r_reject       <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            // Pulse outputs fall unless a transition below raises them.
            r_ship_we  <= '0;
            r_ship_clr <= 1'b0;
            r_reject   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (sp.i_start) begin
                        r_state    <= S_CLEAR;
                        r_ship_clr <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    r_occupied     <= '0;
                    r_ships_placed <= PW'(0);
                    r_ship_idx     <= IW'(0);
                    r_row          <= RW'(0);
                    r_col          <= CLW'(0);
                    r_cursor       <= 5'd0;
                    r_state        <= S_SELECT;
                end
                S_SELECT: begin
                    // Confirm outranks movement, so the cursor stays frozen on confirm.
                    if (sp.i_btn_confirm) begin
                        r_state <= S_CHECK;
                    end else if (w_move) begin
                        r_row    <= w_row_nxt;
                        r_col    <= w_col_nxt;
                        r_cursor <= w_cursor_nxt;
                    end
                end
                S_CHECK: begin
                    if ((r_occupied & w_cell_mask) != '0) begin
                        r_reject <= 1'b1;
                        r_state  <= S_SELECT;
                    end else begin
                        r_ship_we <= NUM_SHIPS'(1) << r_ship_idx;
                        r_state   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_occupied     <= r_occupied | w_cell_mask;
                    r_ships_placed <= r_ships_placed + PW'(1);
                    r_ship_idx     <= r_ship_idx + IW'(1);
                    if (r_ship_idx == IW'(NUM_SHIPS - 1)) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_SELECT;
                    end
                end
                S_DONE: begin
                    if (sp.i_start) begin
                        r_state    <= S_CLEAR;
                        r_ship_clr <= 1'b1;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign sp.o_cursor       = r_cursor;
    assign sp.o_cell_out     = r_cursor;
    assign sp.o_ship_we      = r_ship_we;
    assign sp.o_ship_clr     = r_ship_clr;
    assign sp.o_occupied     = r_occupied;
    assign sp.o_ships_placed = r_ships_placed;
    assign sp.o_reject       = r_reject;
    assign sp.o_busy         = r_busy;
    assign sp.o_done         = r_done;
endmodule

// File: tb/tb_ship_placement_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ship_placement_ctrl
// Cycle-by-cycle vector bench for ship_placement_ctrl (5 ships, 5x5 board).
// Each record holds the inputs for one clock and the outputs expected just
// after that edge; expectations are queued as stimulus is driven and popped
// when the outputs are sampled.
// ----------------------------------------------------------------------------
module tb_ship_placement_ctrl;
    localparam logic [4:0] NO = 5'b00000;
    localparam logic [4:0] UP = 5'b00001;
    localparam logic [4:0] DN = 5'b00010;
    localparam logic [4:0] LF = 5'b00100;
    localparam logic [4:0] RT = 5'b01000;
    localparam logic [4:0] CF = 5'b10000;

    typedef struct {
        logic [4:0]  btn;     // {confirm,right,left,down,up}
        logic        start;
        logic        rst;
        logic [4:0]  cursor;  // cell_out is expected to equal this as well
        logic [4:0]  we;
        logic        clr;
        logic [24:0] occ;
        logic [2:0]  placed;
        logic        reject;
        logic        busy;
        logic        done;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t sb_q[$];
    vec_t tbl[$];

    ship_placement_ctrl_if #(.NUM_SHIPS(5), .ROWS(5), .COLS(5)) bus ();

    ship_placement_ctrl #(.NUM_SHIPS(5), .ROWS(5), .COLS(5)) dut (
        .clk (clk),
        .rst (rst),
        .sp  (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [4:0] btn, input logic st, input logic rs,
                                input logic [4:0] cur, input logic [4:0] we, input logic clr,
                                input logic [24:0] occ, input logic [2:0] pl, input logic rej,
                                input logic bsy, input logic dn);
        vec_t v;
        v.btn = btn; v.start = st; v.rst = rs; v.cursor = cur; v.we = we; v.clr = clr;
        v.occ = occ; v.placed = pl; v.reject = rej; v.busy = bsy; v.done = dn;
        return v;
    endfunction

    task automatic chk(input string name, input int step_no, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, step_no, act, exp);
        end
    endtask

    // Drive one cycle of inputs, queue its expectation, then sample and compare.
    task automatic step(input vec_t v, input int step_no);
        vec_t e;
        @(negedge clk);
        rst               = v.rst;
        bus.i_start       = v.start;
        bus.i_btn_up      = v.btn[0];
        bus.i_btn_down    = v.btn[1];
        bus.i_btn_left    = v.btn[2];
        bus.i_btn_right   = v.btn[3];
        bus.i_btn_confirm = v.btn[4];
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("cursor",   step_no, 32'(bus.o_cursor),       32'(e.cursor));
        chk("cell_out", step_no, 32'(bus.o_cell_out),     32'(e.cursor));
        chk("ship_we",  step_no, 32'(bus.o_ship_we),      32'(e.we));
        chk("ship_clr", step_no, 32'(bus.o_ship_clr),     32'(e.clr));
        chk("occupied", step_no, 32'(bus.o_occupied),     32'(e.occ));
        chk("placed",   step_no, 32'(bus.o_ships_placed), 32'(e.placed));
        chk("reject",   step_no, 32'(bus.o_reject),       32'(e.reject));
        chk("busy",     step_no, 32'(bus.o_busy),         32'(e.busy));
        chk("done",     step_no, 32'(bus.o_done),         32'(e.done));
    endtask

    initial begin
        logic [24:0] occ;
        int          sn;
        bus.i_start = 1'b0; bus.i_btn_up = 1'b0; bus.i_btn_down = 1'b0;
        bus.i_btn_left = 1'b0; bus.i_btn_right = 1'b0; bus.i_btn_confirm = 1'b0;

        //             btn    st    rs    cur    we        clr   occ          pl    rej   bsy   dn
        tbl.push_back(mk(NO, 1'b0, 1'b1, 5'd0,  5'b00000, 1'b0, 25'h0000000, 3'd0, 1'b0, 1'b0, 1'b0)); // reset
        tbl.push_back(mk(NO, 1'b1, 1'b0, 5'd0,  5'b00000, 1'b1, 25'h0000000, 3'd0, 1'b0, 1'b1, 1'b0)); // start->CLEAR
        tbl.push_back(mk(NO, 1'b0, 1'b0, 5'd0,  5'b00000, 1'b0, 25'h0000000, 3'd0, 1'b0, 1'b1, 1'b0)); // SELECT
        tbl.push_back(mk(LF, 1'b0, 1'b0, 5'd4,  5'b00000, 1'b0, 25'h0000000, 3'd0, 1'b0, 1'b1, 1'b0)); // col wrap
        tbl.push_back(mk(UP, 1'b0, 1'b0, 5'd24, 5'b00000, 1'b0, 25'h0000000, 3'd0, 1'b0, 1'b1, 1'b0)); // row wrap
        tbl.push_back(mk(RT, 1'b0, 1'b0, 5'd20, 5'b00000, 1'b0, 25'h0000000, 3'd0, 1'b0, 1'b1, 1'b0)); // col wrap
        tbl.push_back(mk(DN, 1'b0, 1'b0, 5'd0,  5'b00000, 1'b0, 25'h0000000, 3'd0, 1'b0, 1'b1, 1'b0)); // row wrap
        tbl.push_back(mk(RT, 1'b0, 1'b0, 5'd1,  5'b00000, 1'b0, 25'h0000000, 3'd0, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(RT, 1'b0, 1'b0, 5'd2,  5'b00000, 1'b0, 25'h0000000, 3'd0, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(CF, 1'b0, 1'b0, 5'd2,  5'b00000, 1'b0, 25'h0000000, 3'd0, 1'b0, 1'b1, 1'b0)); // CHECK
        tbl.push_back(mk(NO, 1'b0, 1'b0, 5'd2,  5'b00001, 1'b0, 25'h0000000, 3'd0, 1'b0, 1'b1, 1'b0)); // WRITE ship0
        tbl.push_back(mk(NO, 1'b0, 1'b0, 5'd2,  5'b00000, 1'b0, 25'h0000004, 3'd1, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(CF, 1'b0, 1'b0, 5'd2,  5'b00000, 1'b0, 25'h0000004, 3'd1, 1'b0, 1'b1, 1'b0)); // collision CHECK
        tbl.push_back(mk(NO, 1'b0, 1'b0, 5'd2,  5'b00000, 1'b0, 25'h0000004, 3'd1, 1'b1, 1'b1, 1'b0)); // reject pulse
        tbl.push_back(mk(NO, 1'b0, 1'b0, 5'd2,  5'b00000, 1'b0, 25'h0000004, 3'd1, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(DN, 1'b0, 1'b0, 5'd7,  5'b00000, 1'b0, 25'h0000004, 3'd1, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(CF, 1'b0, 1'b0, 5'd7,  5'b00000, 1'b0, 25'h0000004, 3'd1, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(NO, 1'b0, 1'b0, 5'd7,  5'b00010, 1'b0, 25'h0000004, 3'd1, 1'b0, 1'b1, 1'b0)); // WRITE ship1
        tbl.push_back(mk(NO, 1'b0, 1'b0, 5'd7,  5'b00000, 1'b0, 25'h0000084, 3'd2, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(DN, 1'b0, 1'b0, 5'd12, 5'b00000, 1'b0, 25'h0000084, 3'd2, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(CF|RT, 1'b0, 1'b0, 5'd12, 5'b00000, 1'b0, 25'h0000084, 3'd2, 1'b0, 1'b1, 1'b0)); // confirm wins
        tbl.push_back(mk(NO, 1'b0, 1'b0, 5'd12, 5'b00100, 1'b0, 25'h0000084, 3'd2, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(NO, 1'b0, 1'b0, 5'd12, 5'b00000, 1'b0, 25'h0001084, 3'd3, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(RT, 1'b0, 1'b0, 5'd13, 5'b00000, 1'b0, 25'h0001084, 3'd3, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(CF, 1'b0, 1'b0, 5'd13, 5'b00000, 1'b0, 25'h0001084, 3'd3, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(NO, 1'b1, 1'b0, 5'd13, 5'b01000, 1'b0, 25'h0001084, 3'd3, 1'b0, 1'b1, 1'b0)); // start ignored
        tbl.push_back(mk(NO, 1'b0, 1'b0, 5'd13, 5'b00000, 1'b0, 25'h0003084, 3'd4, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(RT, 1'b0, 1'b0, 5'd14, 5'b00000, 1'b0, 25'h0003084, 3'd4, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(CF, 1'b0, 1'b0, 5'd14, 5'b00000, 1'b0, 25'h0003084, 3'd4, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(NO, 1'b0, 1'b0, 5'd14, 5'b10000, 1'b0, 25'h0003084, 3'd4, 1'b0, 1'b1, 1'b0)); // last ship
        tbl.push_back(mk(NO, 1'b0, 1'b0, 5'd14, 5'b00000, 1'b0, 25'h0007084, 3'd5, 1'b0, 1'b0, 1'b1)); // DONE
        tbl.push_back(mk(CF|RT, 1'b0, 1'b0, 5'd14, 5'b00000, 1'b0, 25'h0007084, 3'd5, 1'b0, 1'b0, 1'b1)); // ignored
        tbl.push_back(mk(UP, 1'b0, 1'b0, 5'd14, 5'b00000, 1'b0, 25'h0007084, 3'd5, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(NO, 1'b1, 1'b0, 5'd14, 5'b00000, 1'b1, 25'h0007084, 3'd5, 1'b0, 1'b1, 1'b0)); // restart
        tbl.push_back(mk(NO, 1'b0, 1'b0, 5'd0,  5'b00000, 1'b0, 25'h0000000, 3'd0, 1'b0, 1'b1, 1'b0)); // cleared
        tbl.push_back(mk(NO, 1'b1, 1'b0, 5'd0,  5'b00000, 1'b0, 25'h0000000, 3'd0, 1'b0, 1'b1, 1'b0)); // start ignored

        sn = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], sn);
            sn++;
        end

        // Place ships 0..2 at cells 1..3, then reset during ship 3's CHECK cycle.
        occ = 25'h0;
        for (int s = 0; s < 3; s++) begin
            step(mk(RT, 1'b0, 1'b0, 5'(s + 1), 5'b00000, 1'b0, occ, 3'(s), 1'b0, 1'b1, 1'b0), sn++);
            step(mk(CF, 1'b0, 1'b0, 5'(s + 1), 5'b00000, 1'b0, occ, 3'(s), 1'b0, 1'b1, 1'b0), sn++);
            step(mk(NO, 1'b0, 1'b0, 5'(s + 1), 5'(1 << s), 1'b0, occ, 3'(s), 1'b0, 1'b1, 1'b0), sn++);
            occ = occ | (25'h1 << (s + 1));
            step(mk(NO, 1'b0, 1'b0, 5'(s + 1), 5'b00000, 1'b0, occ, 3'(s + 1), 1'b0, 1'b1, 1'b0), sn++);
        end
        step(mk(RT, 1'b0, 1'b0, 5'd4, 5'b00000, 1'b0, 25'h000000E, 3'd3, 1'b0, 1'b1, 1'b0), sn++);
        step(mk(CF, 1'b0, 1'b0, 5'd4, 5'b00000, 1'b0, 25'h000000E, 3'd3, 1'b0, 1'b1, 1'b0), sn++);
        step(mk(NO, 1'b0, 1'b1, 5'd0, 5'b00000, 1'b0, 25'h0000000, 3'd0, 1'b0, 1'b0, 1'b0), sn++); // rst in CHECK
        step(mk(NO, 1'b0, 1'b0, 5'd0, 5'b00000, 1'b0, 25'h0000000, 3'd0, 1'b0, 1'b0, 1'b0), sn++); // no late we
        step(mk(RT, 1'b0, 1'b0, 5'd0, 5'b00000, 1'b0, 25'h0000000, 3'd0, 1'b0, 1'b0, 1'b0), sn++); // IDLE ignores
        step(mk(NO, 1'b1, 1'b0, 5'd0, 5'b00000, 1'b1, 25'h0000000, 3'd0, 1'b0, 1'b1, 1'b0), sn++); // start again

        @(negedge clk);
        bus.i_start = 1'b0;
        bus.i_btn_right = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ship_placement_ctrl.md
Name: ship_placement_ctrl

Overview:
Sequences the placement phase of the battleship game. It drives a board cursor from player button pulses and validates each confirmed cell against cells already taken. On a valid confirm it write-enables the next per-ship position register and presents the cell index on its 5-bit casilla bus. It sits between the debounced button/input logic and the bank of per-ship position registers, and signals the game FSM when all ships are placed.

Parameters:
NUM_SHIPS, 5, number of ships (and ship registers) to place, in order 0..NUM_SHIPS-1
ROWS, 5, board rows; ROWS*COLS must be <= 32
COLS, 5, board columns; cell index = row*COLS + col

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  begin/restart placement; honoured only in IDLE or DONE
btn_up  in  1  single-cycle pulse: row-1, wraps 0->ROWS-1
btn_down  in  1  single-cycle pulse: row+1, wraps ROWS-1->0
btn_left  in  1  single-cycle pulse: col-1, wraps 0->COLS-1, row unchanged
btn_right  in  1  single-cycle pulse: col+1, wraps COLS-1->0, row unchanged
btn_confirm  in  1  single-cycle pulse: place current ship at cursor
cursor  out  5  current cursor cell index
cell_out  out  5  cell index for ship registers; equals cursor register
ship_we  out  NUM_SHIPS  one-hot write enable to ship register ship_idx
ship_clr  out  1  one-cycle pulse that clears all ship registers on (re)start
occupied  out  ROWS*COLS  bit i set when cell i holds a placed ship
ships_placed  out  $clog2(NUM_SHIPS+1)  count of ships written
reject  out  1  one-cycle pulse: confirm on an occupied cell
busy  out  1  high in CLEAR/SELECT/CHECK/WRITE
done  out  1  high in DONE

Behaviour:
- Reset: state IDLE; cursor=0, cell_out=0, ship_we=0, ship_clr=0, occupied=0, ships_placed=0, ship_idx=0, reject=0, busy=0, done=0. Reset wins over all inputs in the same cycle.
- Internal row/col counters; cursor = row*COLS+col, registered. All outputs are registered or Moore outputs of state.
- IDLE: start -> CLEAR.
- CLEAR (1 cycle): ship_clr=1; occupied, ships_placed, ship_idx, row, col <= 0; -> SELECT.
- SELECT: one action per cycle, priority confirm > up > down > left > right.
  - Move buttons update row/col with wrap.
  - confirm -> CHECK, cursor frozen.
- CHECK (1 cycle): move/confirm ignored.
  - If occupied[cursor]: reject=1 next cycle (one pulse), -> SELECT, ship_idx unchanged.
  - Else -> WRITE.
- WRITE (1 cycle): ship_we = 1<<ship_idx, cell_out=cursor; at cycle end occupied[cursor]<=1, ship_idx++, ships_placed++.
  - If ship_idx was NUM_SHIPS-1 -> DONE, else -> SELECT.
- Latency: confirm sampled at edge k; CHECK during cycle k..k+1; ship_we high during cycle k+1..k+2, captured by the ship register at edge k+2. Exactly one ship_we bit is high per placement, never more than one cycle.
- DONE: done=1, busy=0; buttons ignored, occupied/ships_placed held; start -> CLEAR.
- start in CLEAR/SELECT/CHECK/WRITE: ignored.
- rst mid-operation (any state, including WRITE): ship_we deasserted next cycle, occupied cleared, -> IDLE. Ship registers are cleared by their own rst, not by this block.
- ship_we, ship_clr, reject are never high in IDLE or DONE.

Test Plan:
- rst, then start pulse -> ship_clr=1 for exactly 1 cycle, then busy=1, cursor=0, occupied=0, ships_placed=0.
- Wrap, in SELECT at cursor 0 -> btn_left gives cursor=4; btn_up gives cursor=24; btn_right gives cursor=20; btn_down gives cursor=0.
- Placement, btn_right x2 then btn_confirm at cycle t -> ship_we=5'b00001 during cycle t+2 only, cell_out=2; then occupied[2]=1, ships_placed=1.
- Collision, with ship 0 at cell 2, confirm at cell 2 -> reject one pulse, no ship_we, ships_placed=1. Move to 7 and confirm -> ship_we=5'b00010, cell_out=7.
- Simultaneous btn_confirm+btn_right at cursor 12 -> confirm wins, cell_out=12, cursor not moved. Place 5 ships -> done=1, busy=0, ships_placed=5, buttons ignored. start -> ship_clr pulse, occupied=0.
- rst asserted during the CHECK cycle of ship 3 -> no ship_we ever asserted for that confirm, IDLE, occupied=0, ships_placed=0.
